// File: rtl/regfile_param.sv
// Parametrised register file. Provides two combinational read ports and one write port,
// an optional hardwired zero register, optional write-to-read bypass and a soft-clear sweep.
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                wr_en;

    assign busy       = (state_q == SWEEP);
    assign clear_done = (state_q == DONE);

    // Writes are dropped while sweeping and, when r0 is hardwired, to address 0.
    assign wr_en = regwrite && !busy && !((ZERO_REG != 0) && (waddr == '0));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + ADDR_W'(1);
                if (&ptr_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mem_q   <= mem_d;
        end
    end

    // Priority: hardwired zero beats bypass beats stored contents.
    always_comb begin
        rdata1 = mem_q[raddr1];
        if ((BYPASS != 0) && wr_en && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
        end
    end

    always_comb begin
        rdata2 = mem_q[raddr2];
        if ((BYPASS != 0) && wr_en && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
        if ((ZERO_REG != 0) && (raddr2 == '0)) begin
            rdata2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: dut_a uses ZERO_REG=1/BYPASS=1, dut_b uses
// ZERO_REG=0/BYPASS=0; both share all inputs.
`timescale 1ns/10ps
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        clear_req;
    logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
    logic        busy_a, busy_b, clear_done_a, clear_done_b;

    int passed = 0;
    int total  = 0;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .regwrite(regwrite), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_a), .rdata2(rdata2_a),
        .clear_req(clear_req), .busy(busy_a), .clear_done(clear_done_a)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .regwrite(regwrite), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
        .clear_req(clear_req), .busy(busy_b), .clear_done(clear_done_b)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic seen;
        logic [31:0] exp_v;

        rst = 1'b1; regwrite = 1'b0; waddr = '0; wdata = '0;
        raddr1 = 5'd5; raddr2 = 5'd31; clear_req = 1'b0;
        tick(); tick();
        chk("reset_rd1", rdata1_a, 32'h0);
        chk("reset_rd2", rdata2_b, 32'h0);
        chk("reset_busy", {31'b0, busy_a}, 32'h0);
        chk("reset_done", {31'b0, clear_done_a}, 32'h0);
        rst = 1'b0;
        tick();

        // r5 write; A bypasses before the edge, B shows the old value
        regwrite = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5;
        #1;
        chk("r5_bypass_a", rdata1_a, 32'hDEADBEEF);
        chk("r5_nobypass_b", rdata1_b, 32'h0);
        tick();
        regwrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(a);
            #0.25;
            exp_v = (a == 5) ? 32'hDEADBEEF : 32'h0;
            chk($sformatf("r5_scan_a_%0d", a), rdata1_a, exp_v);
            chk($sformatf("r5_scan_b_%0d", a), rdata2_b, exp_v);
        end

        // register 0 behaviour
        regwrite = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0;
        #1;
        chk("r0_pre_a", rdata1_a, 32'h0);
        chk("r0_pre_b", rdata1_b, 32'h0);
        tick();
        regwrite = 1'b0;
        #1;
        chk("r0_post_a", rdata1_a, 32'h0);
        chk("r0_post_b", rdata1_b, 32'h12345678);

        // dual-port bypass on r7
        regwrite = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        chk("byp_rd1_a", rdata1_a, 32'hA5A5A5A5);
        chk("byp_rd2_a", rdata2_a, 32'hA5A5A5A5);
        chk("nobyp_rd1_b", rdata1_b, 32'h0);
        chk("nobyp_rd2_b", rdata2_b, 32'h0);
        tick();
        regwrite = 1'b0;
        #1;
        chk("r7_post_b1", rdata1_b, 32'hA5A5A5A5);
        chk("r7_post_b2", rdata2_b, 32'hA5A5A5A5);

        // fill all registers with 0x100+a
        for (int a = 0; a < 32; a++) begin
            regwrite = 1'b1; waddr = 5'(a); wdata = 32'h100 + 32'(a);
            tick();
        end
        regwrite = 1'b0;

        // sweep: clear_req sampled at edge k
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("sweep_busy_k", {31'b0, busy_a}, 32'h1);
        chk("sweep_busy_k_b", {31'b0, busy_b}, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        regwrite = 1'b1; waddr = 5'd3; wdata = 32'h1; raddr1 = 5'd3;
        #1;
        chk("sweep_no_bypass", rdata1_a, 32'h0);
        tick();
        regwrite = 1'b0;
        chk("sweep_wr_drop_a", rdata1_a, 32'h0);
        chk("sweep_wr_drop_b", rdata1_b, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            #0.25;
            exp_v = (a < 16) ? 32'h0 : 32'h100 + 32'(a);
            chk($sformatf("mid_a_%0d", a), rdata1_a, exp_v);
            chk($sformatf("mid_b_%0d", a), rdata1_b, exp_v);
        end
        for (int i = 0; i < 15; i++) tick();
        chk("k31_busy", {31'b0, busy_a}, 32'h1);
        chk("k31_done", {31'b0, clear_done_a}, 32'h0);
        tick();
        chk("k32_busy", {31'b0, busy_a}, 32'h0);
        chk("k32_done_a", {31'b0, clear_done_a}, 32'h1);
        chk("k32_done_b", {31'b0, clear_done_b}, 32'h1);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(a);
            #0.25;
            chk($sformatf("post_a_%0d", a), rdata1_a, 32'h0);
            chk($sformatf("post_b_%0d", a), rdata2_b, 32'h0);
        end
        tick();
        chk("k33_done", {31'b0, clear_done_a}, 32'h0);

        // asynchronous reset in the middle of a sweep
        regwrite = 1'b1; waddr = 5'd10; wdata = 32'h0000CAFE;
        tick();
        regwrite = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_busy", {31'b0, busy_a}, 32'h1);
        raddr1 = 5'd10;
        #0.25;
        chk("pre_rst_r10", rdata1_a, 32'h0000CAFE);
        #4;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy_a", {31'b0, busy_a}, 32'h0);
        chk("rst_mid_busy_b", {31'b0, busy_b}, 32'h0);
        chk("rst_mid_r10_a", rdata1_a, 32'h0);
        chk("rst_mid_r10_b", rdata1_b, 32'h0);
        raddr1 = 5'd31;
        #0.25;
        chk("rst_mid_r31_b", rdata1_b, 32'h0);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (busy_a || clear_done_a || clear_done_b) seen = 1'b1;
        end
        chk("rst_no_done", {31'b0, seen}, 32'h0);

        regwrite = 1'b1; waddr = 5'd12; wdata = 32'h77;
        tick();
        regwrite = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (n < 40 && !clear_done_a) begin
            tick();
            n++;
        end
        chk("resweep_len", 32'(n), 32'd32);
        raddr1 = 5'd12;
        #0.25;
        chk("resweep_r12", rdata1_a, 32'h0);
        tick();

        // write and clear_req together in IDLE; clear_req held through DONE
        regwrite = 1'b1; waddr = 5'd9; wdata = 32'h55; raddr1 = 5'd9; clear_req = 1'b1;
        #1;
        chk("r9_bypass", rdata1_a, 32'h55);
        tick();
        regwrite = 1'b0;
        chk("r9_written_a", rdata1_a, 32'h55);
        chk("r9_written_b", rdata1_b, 32'h55);
        chk("r9_busy", {31'b0, busy_a}, 32'h1);
        for (int i = 0; i < 9; i++) tick();
        chk("r9_before_clr", rdata1_a, 32'h55);
        tick();
        chk("r9_cleared", rdata1_a, 32'h0);
        for (int i = 0; i < 22; i++) tick();
        chk("hold_done", {31'b0, clear_done_a}, 32'h1);
        tick();
        chk("hold_no_retrig", {31'b0, busy_a}, 32'h0);
        chk("hold_done_low", {31'b0, clear_done_a}, 32'h0);
        clear_req = 1'b0;
        tick();
        chk("hold_idle", {31'b0, busy_b}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
